rx_control: RTL and testbench

Receive-side controller for the serial link driven by the transmit-side address/strobe generator. It consumes the transmit clock `txc`, the frame strobe `instrobe` (the transmitter's `outstrobe`) and serial data `rxd`, all synchronous to `clock`. It locks to the frame boundary, deserialises MSB-first words and writes each completed word into the receive data store through a write-address/write-enable port.

---
 rtl/rx_control.sv | 130 +++++++++++++
 tb/tb_rx_control.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_control.sv
// Receive-side link controller: locks to the transmitter frame strobe, deserialises
// MSB-first words on txc rising edges and writes them into the receive store.
//
// state  | meaning
// IDLE   | waiting for the first instrobe fall; txc edges ignored
// RUN    | locked to the frame; shifting bits and issuing writes
module rx_control #(
  parameter int counter_size = 4,
  parameter int word_width   = 8,
  parameter int adrs_width   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  txc,
  input  logic                  instrobe,
  input  logic                  rxd,
  output logic [adrs_width-1:0] wradrs,
  output logic [word_width-1:0] wrdata,
  output logic                  wrenable,
  output logic                  locked,
  output logic                  frame_err
);

  localparam int              CW       = (word_width > 1) ? $clog2(word_width) : 1;
  localparam logic [CW-1:0]   LAST_BIT = CW'(word_width - 1);
  localparam logic [0:0]      S_IDLE   = 1'b0;
  localparam logic [0:0]      S_RUN    = 1'b1;

  // A frame must hold a whole number of words, otherwise every frame would flag an error.
  generate
    if ((word_width < 2) || (((1 << counter_size) % word_width) != 0)) begin : g_bad_geometry
      $error("rx_control: word_width must be >= 2 and divide 2**counter_size");
    end
  endgenerate

  logic [0:0]            state_q, state_d;
  logic                  txc_prev_q, txc_prev_d;
  logic                  instrobe_prev_q, instrobe_prev_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [word_width-1:0] shreg_q, shreg_d;
  logic [word_width-1:0] wrdata_q, wrdata_d;
  logic                  wrenable_q, wrenable_d;
  logic [adrs_width-1:0] wradrs_q, wradrs_d;
  logic                  frame_err_q, frame_err_d;

  logic                  txc_rise;
  logic                  resync;
  logic [CW-1:0]         cnt_eff;

  assign txc_rise = txc & ~txc_prev_q;
  assign resync   = instrobe_prev_q & ~instrobe;

  always_comb begin
    state_d         = state_q;
    txc_prev_d      = txc;
    instrobe_prev_d = instrobe;
    bit_cnt_d       = bit_cnt_q;
    shreg_d         = shreg_q;
    wrdata_d        = wrdata_q;
    wrenable_d      = 1'b0;
    wradrs_d        = wradrs_q;
    frame_err_d     = frame_err_q;
    cnt_eff         = bit_cnt_q;

    if (wrenable_q) begin
      wradrs_d = wradrs_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (resync) begin
          state_d   = S_RUN;
          bit_cnt_d = '0;
        end
      end
      S_RUN: begin
        // Resync takes effect before a coincident txc edge, so that bit opens the new word.
        if (resync) begin
          if (bit_cnt_q != '0) begin
            frame_err_d = 1'b1;
          end
          cnt_eff   = '0;
          bit_cnt_d = '0;
        end
        if (txc_rise) begin
          shreg_d = {shreg_q[word_width-2:0], rxd};
          if (cnt_eff == LAST_BIT) begin
            wrdata_d   = {shreg_q[word_width-2:0], rxd};
            wrenable_d = 1'b1;
            bit_cnt_d  = '0;
          end else begin
            bit_cnt_d = cnt_eff + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      txc_prev_q      <= 1'b0;
      instrobe_prev_q <= 1'b0;
      bit_cnt_q       <= '0;
      shreg_q         <= '0;
      wrdata_q        <= '0;
      wrenable_q      <= 1'b0;
      wradrs_q        <= '0;
      frame_err_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      txc_prev_q      <= txc_prev_d;
      instrobe_prev_q <= instrobe_prev_d;
      bit_cnt_q       <= bit_cnt_d;
      shreg_q         <= shreg_d;
      wrdata_q        <= wrdata_d;
      wrenable_q      <= wrenable_d;
      wradrs_q        <= wradrs_d;
      frame_err_q     <= frame_err_d;
    end
  end

  assign wradrs    = wradrs_q;
  assign wrdata    = wrdata_q;
  assign wrenable  = wrenable_q;
  assign locked    = (state_q == S_RUN);
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_rx_control.sv
// Bench for rx_control: a queue-based receiver model checked every clock, plus
// write-log checks against tables of expected words for the directed scenarios.
module tb_rx_control;

  logic       clock = 1'b0;
  logic       reset;
  logic       txc, instrobe, rxd;
  logic [3:0] wradrs;
  logic [7:0] wrdata;
  logic       wrenable, locked, frame_err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  rx_control #(.counter_size(4), .word_width(8), .adrs_width(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .txc      (txc),
    .instrobe (instrobe),
    .rxd      (rxd),
    .wradrs   (wradrs),
    .wrdata   (wrdata),
    .wrenable (wrenable),
    .locked   (locked),
    .frame_err(frame_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int adrs; int data; int cyc; } wr_t;
  wr_t wlog[$];

  always @(negedge clock) begin
    if (reset === 1'b1 && wrenable === 1'b1) wlog.push_back('{int'(wradrs), int'(wrdata), cyc});
  end

  typedef struct { logic [7:0] data; logic [3:0] adrs; } vec_t;
  vec_t tbl[20];

  // Reference receiver: bits of the word in progress kept as a queue.
  bit m_locked, m_wen, m_ferr, ptxc, pinst;
  int m_adrs, m_wdata;
  int bits[$];

  function automatic void model_reset();
    m_locked = 0; m_wen = 0; m_ferr = 0; ptxc = 0; pinst = 0;
    m_adrs = 0; m_wdata = 0;
    bits.delete();
  endfunction

  function automatic void model_clock(bit t, bit s, bit d);
    bit rise = t && !ptxc;
    bit rs   = pinst && !s;
    bit nwen = 0;
    if (m_wen) m_adrs = (m_adrs + 1) % 16;
    if (!m_locked) begin
      if (rs) begin
        m_locked = 1;
        bits.delete();
      end
    end else begin
      if (rs) begin
        if (bits.size() != 0) m_ferr = 1;
        bits.delete();
      end
      if (rise) begin
        bits.push_back(int'(d));
        if (bits.size() == 8) begin
          m_wdata = 0;
          foreach (bits[i]) m_wdata = m_wdata * 2 + bits[i];
          nwen = 1;
          bits.delete();
        end
      end
    end
    m_wen = nwen; ptxc = t; pinst = s;
  endfunction

  task automatic check_model();
    n_cmp++;
    if ({wradrs, wrdata, wrenable, locked, frame_err} !==
        {4'(m_adrs), 8'(m_wdata), m_wen, m_locked, m_ferr}) begin
      n_err++;
      $display("FAIL model cyc=%0d got adrs=%0d data=%02h we=%b lk=%b fe=%b expected adrs=%0d data=%02h we=%b lk=%b fe=%b",
               cyc, wradrs, wrdata, wrenable, locked, frame_err,
               m_adrs, m_wdata, m_wen, m_locked, m_ferr);
    end
  endtask

  task automatic check_val(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic check_zero(string name);
    n_cmp++;
    if ({wradrs, wrdata, wrenable, locked, frame_err} !== 15'd0) begin
      n_err++;
      $display("FAIL %s got adrs=%0d data=%02h we=%b lk=%b fe=%b expected all zero",
               name, wradrs, wrdata, wrenable, locked, frame_err);
    end
  endtask

  task automatic step(bit t, bit s, bit d);
    @(negedge clock);
    check_model();
    txc = t; instrobe = s; rxd = d;
    model_clock(t, s, d);
  endtask

  // mode 0: plain bit; 1: strobe fall during the low phase; 2: strobe fall on the txc rise
  task automatic send_bit(bit b, int mode);
    for (int i = 0; i < 16; i++) step(1'b0, (mode == 1 && i == 0) || (mode == 2 && i == 15), b);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, b);
  endtask

  task automatic send_word(logic [7:0] w, bit strobe_first);
    for (int k = 7; k >= 0; k--) send_bit(w[k], (k == 7 && strobe_first) ? 1 : 0);
  endtask

  task automatic do_reset(string name);
    @(negedge clock);
    reset = 1'b0; txc = 1'b0; instrobe = 1'b0; rxd = 1'b0;
    model_reset();
    #1 check_zero(name);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    bit rt;
    for (int i = 0; i < 20; i++) begin
      tbl[i].data = 8'((i * 37 + 11) & 255);
      tbl[i].adrs = 4'(i % 16);
    end

    reset = 1'b0; txc = 1'b0; instrobe = 1'b0; rxd = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    check_zero("reset_state");
    reset = 1'b1;

    // txc toggling with no strobe fall: must stay unlocked and silent
    for (int i = 0; i < 600; i++) step(1'((i / 16) % 2), 1'b0, 1'($urandom % 2));
    check_val("idle_locked", int'(locked), 0);
    check_val("idle_writes", wlog.size(), 0);

    // first frame after lock
    wlog.delete();
    send_word(8'hA5, 1'b1);
    send_word(8'h3C, 1'b0);
    check_val("lock_locked", int'(locked), 1);
    check_val("frame_writes", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check_val("w0_data", wlog[0].data, 'hA5);
      check_val("w0_adrs", wlog[0].adrs, 0);
      check_val("w1_data", wlog[1].data, 'h3C);
      check_val("w1_adrs", wlog[1].adrs, 1);
      check_val("write_spacing", wlog[1].cyc - wlog[0].cyc, 256);
    end

    // 20-word stream with address wrap
    do_reset("reset_before_stream");
    wlog.delete();
    for (int i = 0; i < 20; i++) send_word(tbl[i].data, (i % 2) == 0);
    check_val("stream_writes", wlog.size(), 20);
    for (int i = 0; i < 20 && i < wlog.size(); i++) begin
      check_val($sformatf("stream%0d_data", i), wlog[i].data, int'(tbl[i].data));
      check_val($sformatf("stream%0d_adrs", i), wlog[i].adrs, int'(tbl[i].adrs));
    end
    check_val("stream_frame_err", int'(frame_err), 0);

    // extra strobe after 3 bits: partial word dropped
    wlog.delete();
    send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
    send_word(8'h5A, 1'b1);
    check_val("partial_frame_err", int'(frame_err), 1);
    check_val("partial_writes", wlog.size(), 1);
    if (wlog.size() == 1) begin
      check_val("partial_next_data", wlog[0].data, 'h5A);
      check_val("partial_next_adrs", wlog[0].adrs, 4);
    end

    // resync coincident with a txc rise carrying 1
    do_reset("reset_before_coincident");
    wlog.delete();
    send_bit(1'b0, 1); send_bit(1'b1, 0);
    send_bit(1'b1, 2);
    for (int k = 6; k >= 0; k--) send_bit(1'(k % 2 == 0 ? 0 : 1), 0);
    check_val("coinc_writes", wlog.size(), 1);
    if (wlog.size() == 1) check_val("coinc_data", wlog[0].data, 'hAA);
    check_val("coinc_frame_err", int'(frame_err), 1);

    // reset mid-word
    do_reset("reset_before_midword");
    send_bit(1'b1, 1); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
    check_val("midword_locked", int'(locked), 1);
    wlog.delete();
    do_reset("reset_midword");
    send_word(8'hC3, 1'b0);
    check_val("post_reset_writes", wlog.size(), 0);
    check_val("post_reset_locked", int'(locked), 0);
    send_word(8'h96, 1'b1);
    check_val("relock_writes", wlog.size(), 1);
    if (wlog.size() == 1) begin
      check_val("relock_data", wlog[0].data, 'h96);
      check_val("relock_adrs", wlog[0].adrs, 0);
    end

    // random framed words
    do_reset("reset_before_random");
    for (int i = 0; i < 6; i++) send_word(8'($urandom), (i % 2) == 0);

    // fully random pin activity
    rt = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(3) == 0) rt = ~rt;
      step(rt, ($urandom_range(40) == 0), 1'($urandom % 2));
    end
    step(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
